// File: rtl/fma_share_arbiter.sv
// fma_share_arbiter: round-robin sharing of one E5M2xE5M2+FP16->FP32 FMA datapath
// among NUM_REQ requesters, with a tag pipeline routing each result back to its issuer
// and a per-requester response register held until the requester accepts it.
module fma_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FMA_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [8*NUM_REQ-1:0]    req_a,
  input  logic [8*NUM_REQ-1:0]    req_b,
  input  logic [16*NUM_REQ-1:0]   req_c,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [32*NUM_REQ-1:0]   rsp_data,
  output logic                    fma_valid,
  output logic [7:0]              fma_a,
  output logic [7:0]              fma_b,
  output logic [15:0]             fma_c,
  input  logic                    fma_out_valid,
  input  logic [31:0]             fma_data,
  output logic                    busy,
  output logic                    err_sync
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_v;
  logic [ID_W-1:0]    grant_id;
  int unsigned        scan;

  logic [FMA_LAT-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [FMA_LAT];
  logic               tail_v;
  logic [ID_W-1:0]    tail_id;

  // Requesters with an op in flight or awaiting accept are masked; nothing is granted in reset
  assign eligible = req_valid & ~pend & {NUM_REQ{~rst}};
  assign tail_v   = tag_v[FMA_LAT-1];
  assign tail_id  = tag_id[FMA_LAT-1];
  assign busy     = |pend;

  // Round-robin scan starting at ptr: first eligible index wins
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    scan     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = (32'(ptr) + k) % NUM_REQ;
      if (!grant_v && eligible[ID_W'(scan)]) begin
        grant_v  = 1'b1;
        grant_id = ID_W'(scan);
      end
    end
  end

  // One-hot grant doubles as req_ready and selects the operands issued to the FMA
  always_comb begin
    grant     = '0;
    fma_valid = grant_v;
    fma_a     = '0;
    fma_b     = '0;
    fma_c     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_v && grant_id == ID_W'(i)) begin
        grant[i] = 1'b1;
        fma_a    = req_a[i*8 +: 8];
        fma_b    = req_b[i*8 +: 8];
        fma_c    = req_c[i*16 +: 16];
      end
    end
  end

  assign req_ready = grant;

  // Tag pipeline mirrors the FMA latency so the tail lines up with fma_out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < FMA_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= grant_v;
      tag_id[0] <= grant_id;
      for (int i = 1; i < FMA_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Pointer, pending flags, response registers and sticky tag/result mismatch flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      pend      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      err_sync  <= 1'b0;
    end else begin
      if (grant_v) begin
        ptr <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
      end
      if (tail_v != fma_out_valid) err_sync <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
          pend[i]      <= 1'b0;
        end
        if (tail_v && tail_id == ID_W'(i)) begin
          if (fma_out_valid) begin
            rsp_valid[i]          <= 1'b1;
            rsp_data[i*32 +: 32]  <= fma_data;
          end else begin
            // Result never arrived: release the requester rather than deadlock it
            pend[i] <= 1'b0;
          end
        end
        if (grant[i]) pend[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fma_share_arbiter.sv
// Directed bench for fma_share_arbiter with a one-cycle stub FMA.
module tb_fma_share_arbiter;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [8*N-1:0]  req_a;
  logic [8*N-1:0]  req_b;
  logic [16*N-1:0] req_c;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [32*N-1:0] rsp_data;
  logic          fma_valid;
  logic [7:0]    fma_a;
  logic [7:0]    fma_b;
  logic [15:0]   fma_c;
  logic          fma_out_valid;
  logic [31:0]   fma_data;
  logic          busy;
  logic          err_sync;

  logic          stub_v;
  logic [31:0]   stub_d;
  logic          inject;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fma_share_arbiter #(.NUM_REQ(N), .FMA_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .fma_valid(fma_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_out_valid(fma_out_valid), .fma_data(fma_data),
    .busy(busy), .err_sync(err_sync)
  );

  // Stub FMA result: exact 1.0*1.0+1.0 = 2.0 case, otherwise operands packed as a signature
  function automatic logic [31:0] stub_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [15:0] c);
    if (a == 8'h3C && b == 8'h3C && c == 16'h3C00) return 32'h4000_0000;
    return {a, b, c};
  endfunction

  function automatic logic [31:0] exp_res(input int i);
    return {8'(8'h10 + i), 8'(8'h20 + i), 16'(16'h3000 + i)};
  endfunction

  // One-cycle FMA stub sharing the arbiter reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_v <= 1'b0;
      stub_d <= '0;
    end else begin
      stub_v <= fma_valid;
      stub_d <= stub_fn(fma_a, fma_b, fma_c);
    end
  end

  assign fma_out_valid = stub_v | inject;
  assign fma_data      = stub_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8]   = 8'(8'h10 + i);
      req_b[i*8 +: 8]   = 8'(8'h20 + i);
      req_c[i*16 +: 16] = 16'(16'h3000 + i);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    int id;
    rst       = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'h0;
    inject    = 1'b0;
    set_ops();

    // Reset state, with requests asserted to show the grant is gated
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_fma_valid", 32'(fma_valid), 0);
    chk("rst_fma_a", 32'(fma_a), 0);
    chk("rst_fma_c", 32'(fma_c), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(|rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_sync), 0);
    adv();
    rst = 1'b0;
    req_valid = 4'h0;

    // Single op 1.0*1.0+1.0 on requester 0
    req_a[7:0]  = 8'h3C;
    req_b[7:0]  = 8'h3C;
    req_c[15:0] = 16'h3C00;
    req_valid   = 4'h1;
    @(negedge clk);
    chk("t1_grant", 32'(req_ready), 32'h1);
    chk("t1_fma_valid", 32'(fma_valid), 1);
    chk("t1_fma_a", 32'(fma_a), 32'h3C);
    chk("t1_fma_b", 32'(fma_b), 32'h3C);
    chk("t1_fma_c", 32'(fma_c), 32'h3C00);
    adv();
    @(negedge clk);
    chk("t1_pend_block", 32'(req_ready), 0);
    chk("t1_rsp_early", 32'(rsp_valid), 0);
    chk("t1_busy", 32'(busy), 1);
    adv();
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data", rsp_data[31:0], 32'h4000_0000);
    adv();
    req_valid = 4'h0;
    rsp_ready = 4'h1;
    @(negedge clk);
    chk("t1_rsp_hold", 32'(rsp_valid), 32'h1);
    adv();
    @(negedge clk);
    chk("t1_rsp_clear", 32'(rsp_valid), 0);
    chk("t1_busy_clear", 32'(busy), 0);
    chk("t1_data_keep", rsp_data[31:0], 32'h4000_0000);
    adv();

    // ptr is now 1: only requesters 0 and 2 -> grant 2 then 0
    set_ops();
    rsp_ready = 4'hF;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("t4_grant2", 32'(req_ready), 32'h4);
    chk("t4_fma_a2", 32'(fma_a), 32'h12);
    adv();
    @(negedge clk);
    chk("t4_grant0", 32'(req_ready), 32'h1);
    chk("t4_fma_c0", 32'(fma_c), 32'h3000);
    adv();
    req_valid = 4'h0;
    @(negedge clk);
    chk("t4_rsp2", 32'(rsp_valid), 32'h4);
    chk("t4_data2", rsp_data[95:64], exp_res(2));
    adv();
    @(negedge clk);
    chk("t4_rsp0", 32'(rsp_valid), 32'h1);
    chk("t4_data0", rsp_data[31:0], exp_res(0));
    adv();
    @(negedge clk);
    chk("t4_idle", 32'(busy), 0);
    adv();

    // All requesting, all accepting: back-to-back rotation starting at ptr=1
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t2_grant", 32'(req_ready), 32'(1) << ((1 + k) % 4));
      chk("t2_fma_valid", 32'(fma_valid), 1);
      if (k >= 2) begin
        id = (k - 1) % 4;
        chk("t2_rsp_valid", 32'(rsp_valid), 32'(1) << id);
        chk("t2_rsp_data", rsp_data[id*32 +: 32], exp_res(id));
      end
      adv();
    end
    req_valid = 4'h0;
    repeat (3) adv();
    @(negedge clk);
    chk("t2_drain_busy", 32'(busy), 0);
    chk("t2_drain_rsp", 32'(rsp_valid), 0);
    adv();

    // Requester 1 stalls its response: it holds, others keep rotating
    rsp_ready = 4'b1101;
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) g = 1;
      else begin
        case ((k - 1) % 3)
          0:       g = 2;
          1:       g = 3;
          default: g = 0;
        endcase
      end
      chk("t3_grant", 32'(req_ready), 32'(1) << g);
      if (k >= 2) begin
        chk("t3_rsp1_hold", 32'(rsp_valid[1]), 1);
        chk("t3_data1_hold", rsp_data[63:32], exp_res(1));
      end
      adv();
    end
    rsp_ready = 4'hF;
    req_valid = 4'h0;
    repeat (3) adv();
    @(negedge clk);
    chk("t3_drain_busy", 32'(busy), 0);
    adv();

    // Spurious fma_out_valid with an empty tag tail
    @(negedge clk);
    chk("t5_err_before", 32'(err_sync), 0);
    adv();
    inject = 1'b1;
    adv();
    inject = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 32'(err_sync), 1);
    chk("t5_no_rsp", 32'(rsp_valid), 0);
    adv();
    adv();
    @(negedge clk);
    chk("t5_err_sticky", 32'(err_sync), 1);
    adv();

    // Reset with two ops in flight
    rsp_ready = 4'h0;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("t6_grant0", 32'(req_ready), 32'h1);
    adv();
    @(negedge clk);
    chk("t6_grant1", 32'(req_ready), 32'h2);
    adv();
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("t6_req_ready", 32'(req_ready), 0);
    chk("t6_fma_valid", 32'(fma_valid), 0);
    chk("t6_fma_a", 32'(fma_a), 0);
    chk("t6_fma_b", 32'(fma_b), 0);
    chk("t6_fma_c", 32'(fma_c), 0);
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_rsp_data", 32'(|rsp_data), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_err", 32'(err_sync), 0);
    adv();
    rst = 1'b0;
    req_valid = 4'h0;
    rsp_ready = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_stale_rsp", 32'(rsp_valid), 0);
      chk("t6_idle_busy", 32'(busy), 0);
      adv();
    end
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_rotate", 32'(req_ready), 32'(1) << k);
      adv();
    end
    req_valid = 4'h0;
    repeat (4) adv();
    @(negedge clk);
    chk("t6_final_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
